// File: rtl/div_unit.sv
// Multi-cycle restoring divider for the EX stage.
// One quotient bit per clock; signed or unsigned operands.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    FREE,
    ZERO,
    ON,
    END
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CW-1:0]      cnt_q;
  logic [CW-1:0]      cnt_d;
  logic [2*WIDTH:0]   work_q;
  logic [2*WIDTH:0]   work_d;
  logic [WIDTH-1:0]   dvs_q;
  logic [WIDTH-1:0]   dvs_d;
  logic               neg_q_q;
  logic               neg_q_d;
  logic               neg_r_q;
  logic               neg_r_d;
  logic [2*WIDTH-1:0] result_d;
  logic               ready_d;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   q_mag;
  logic [WIDTH-1:0]   r_mag;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;
  logic [WIDTH:0]     diff;
  logic               a_neg;
  logic               b_neg;

  always_comb begin
    a_neg = signed_div_i & opdata1_i[WIDTH-1];
    b_neg = signed_div_i & opdata2_i[WIDTH-1];
    a_mag = a_neg ? -opdata1_i : opdata1_i;
    b_mag = b_neg ? -opdata2_i : opdata2_i;
    diff  = work_q[2*WIDTH:WIDTH] - {1'b0, dvs_q};
    q_mag = work_q[WIDTH-1:0];
    r_mag = work_q[2*WIDTH:WIDTH+1];
    q_fix = neg_q_q ? -q_mag : q_mag;
    r_fix = neg_r_q ? -r_mag : r_mag;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    dvs_d    = dvs_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    result_d = result_o;
    ready_d  = ready_o;
    unique case (state_q)
      FREE: begin
        result_d = '0;
        ready_d  = 1'b0;
        if (start_i && !annul_i) begin
          cnt_d = '0;
          if (opdata2_i == '0) begin
            state_d = ZERO;
          end else begin
            state_d = ON;
            work_d  = {{WIDTH{1'b0}}, a_mag, 1'b0};
            dvs_d   = b_mag;
            neg_q_d = a_neg ^ b_neg;
            neg_r_d = a_neg;
          end
        end
      end
      ZERO: begin
        // two edges in ZERO so the result lands on E2
        if (cnt_q == '0) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          state_d  = END;
          result_d = '0;
          ready_d  = 1'b1;
        end
      end
      ON: begin
        if (annul_i) begin
          state_d  = FREE;
          cnt_d    = '0;
          result_d = '0;
          ready_d  = 1'b0;
        end else if (cnt_q == CW'(WIDTH)) begin
          state_d  = END;
          result_d = {r_fix, q_fix};
          ready_d  = 1'b1;
        end else begin
          if (diff[WIDTH]) begin
            work_d = {work_q[2*WIDTH-1:0], 1'b0};
          end else begin
            work_d = {diff[WIDTH-1:0],
                      work_q[WIDTH-1:0], 1'b1};
          end
          cnt_d = cnt_q + 1'b1;
        end
      end
      END: begin
        if (!start_i) begin
          state_d  = FREE;
          result_d = '0;
          ready_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= FREE;
      cnt_q    <= '0;
      work_q   <= '0;
      dvs_q    <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      dvs_q    <= dvs_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      result_o <= result_d;
      ready_o  <= ready_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed scoreboard bench for div_unit.
// Monitor pops expected results when ready_o rises.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        signed_div = 1'b0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic        start = 1'b0;
  logic        annul = 1'b0;
  logic [63:0] result;
  logic        ready;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic rdy_q = 1'b0;

  logic [63:0] exp_res_q[$];
  int          exp_cyc_q[$];

  div_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && ready && !rdy_q) begin
      if (exp_res_q.size() == 0) begin
        check("unexpected_ready", 64'(ready), 64'd0);
      end else begin
        check("result", result, exp_res_q.pop_front());
        check("latency", 64'(cyc),
              64'(exp_cyc_q.pop_front()));
      end
    end
    rdy_q = ready;
  end

  task automatic do_op(input logic s,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] q,
                       input logic [31:0] r,
                       input int lat);
    int n;
    @(posedge clk); #1;
    signed_div = s;
    op1 = a;
    op2 = b;
    start = 1'b1;
    exp_res_q.push_back({r, q});
    exp_cyc_q.push_back(cyc + 1 + lat);
    @(posedge clk); #1;
    op1 = $urandom;
    op2 = $urandom;
    signed_div = ~s;
    n = 1;
    while (!ready && n < lat + 8) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready) begin
      check("timeout", 64'(ready), 64'd1);
      if (exp_res_q.size() != 0) begin
        void'(exp_res_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
    check("drop", {63'(result), ready}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_result", result, 64'd0);
    rst = 1'b1;

    do_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
    do_op(1'b1, 32'hFFFFFFF9, 32'd2,
          32'hFFFFFFFD, 32'hFFFFFFFF, 33);
    do_op(1'b1, 32'd7, 32'hFFFFFFFE,
          32'hFFFFFFFD, 32'd1, 33);
    do_op(1'b0, 32'd5, 32'd0, 32'd0, 32'd0, 2);
    do_op(1'b1, 32'hFFFFFFFD, 32'd0, 32'd0, 32'd0, 2);
    do_op(1'b1, 32'h80000000, 32'hFFFFFFFF,
          32'h80000000, 32'd0, 33);
    do_op(1'b0, 32'hFFFFFFFF, 32'd1,
          32'hFFFFFFFF, 32'd0, 33);
    do_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFF9,
          32'd1, 32'd6, 33);

    // annul at step 10
    @(posedge clk); #1;
    signed_div = 1'b0;
    op1 = 32'd100;
    op2 = 32'd7;
    start = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    annul = 1'b1;
    @(posedge clk); #1;
    annul = 1'b0;
    start = 1'b0;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready) bad++;
    end
    check("annul_quiet", 64'(bad), 64'd0);
    do_op(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);

    // reset at step 20
    @(posedge clk); #1;
    signed_div = 1'b0;
    op1 = 32'd100;
    op2 = 32'd7;
    start = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    start = 1'b0;
    check("rst_mid_ready", 64'(ready), 64'd0);
    check("rst_mid_result", result, 64'd0);
    do_op(1'b1, 32'hFFFFFF9C, 32'd7,
          32'hFFFFFFF2, 32'hFFFFFFFE, 33);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", 64'(exp_res_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errors);
    $finish;
  end

endmodule
